// File: rtl/mem_access_unit.sv
// mem_access_unit: single-request load/store initiator for a 1024-word data memory.
// Sub-word stores are a read-modify-write because the memory only writes whole words.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [9:0]  DataAddr,
    output logic [31:0] WriteData,
    output logic        DMRd,
    output logic        DMWr,
    input  logic [31:0] DataOut
);
    localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  op_q;
    logic [11:0] addr_q;
    logic [31:0] wdata_q, old_q, rdata_q;
    logic        err_q;
    logic        accept, req_bad;
    logic [4:0]  sh;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val, mask, merged;

    // op[1:0]: 00 byte, 01 half, 11 word; 10 and stores/loads with op[2] on wide/store ops are illegal
    assign req_bad = (req_op[1:0] == 2'b10) | (req_op[3] & req_op[2]) | (req_op[2] & req_op[1])
                   | (req_op[1] ? |req_addr[1:0] : (req_op[0] & req_addr[0]));
    assign accept  = req_valid && state_q == IDLE;

    assign sh       = {addr_q[1:0], 3'b000};
    assign byte_sel = DataOut[sh +: 8];
    assign half_sel = addr_q[1] ? DataOut[31:16] : DataOut[15:0];
    assign load_val = op_q[1] ? DataOut
                    : op_q[0] ? {{16{~op_q[2] & half_sel[15]}}, half_sel}
                    : {{24{~op_q[2] & byte_sel[7]}}, byte_sel};
    assign mask     = op_q[0] ? 32'h0000_ffff : 32'h0000_00ff;
    assign merged   = op_q[1] ? wdata_q : (old_q & ~(mask << sh)) | ((wdata_q & mask) << sh);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = !accept ? IDLE : req_bad ? DONE : (req_op[3] && req_op[1]) ? WRITE : READ;
            READ:    state_d = op_q[3] ? WRITE : DONE;
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                err_q   <= req_bad;
            end
            if (state_q == READ && op_q[3])
                old_q <= DataOut;
            if (state_q == READ && !op_q[3])
                rdata_q <= load_val;
        end
    end

    // Outputs are gated by rst so an aborted write never reaches the memory
    assign req_ready = rst | (state_q == IDLE);
    assign done      = !rst && state_q == DONE;
    assign err       = done & err_q;
    assign rdata     = rst ? 32'h0 : rdata_q;
    assign DMRd      = !rst && state_q == READ;
    assign DMWr      = !rst && state_q == WRITE;
    assign DataAddr  = (DMRd | DMWr) ? addr_q[11:2] : 10'h0;
    assign WriteData = DMWr ? merged : 32'h0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a behavioural word memory.
module tb_mem_access_unit;
    logic        clk = 0, rst = 1, req_valid = 0;
    logic [3:0]  req_op = 0;
    logic [11:0] req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic        req_ready, done, err, DMRd, DMWr;
    logic [31:0] rdata, WriteData, DataOut;
    logic [9:0]  DataAddr;
    logic [31:0] mem [1024];
    int total = 0, bad = 0;
    int cyc = 0, nw = 0;
    bit mon = 0;
    int wcyc [8];
    logic [31:0] wdat [8];
    logic [9:0]  wadr [8];

    mem_access_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done), .err(err), .rdata(rdata), .DataAddr(DataAddr),
        .WriteData(WriteData), .DMRd(DMRd), .DMWr(DMWr), .DataOut(DataOut)
    );

    always #5 clk = ~clk;
    assign DataOut = mem[DataAddr];
    always @(posedge clk) begin
        if (DMWr) mem[DataAddr] <= WriteData;
        cyc <= cyc + 1;
    end
    always @(negedge clk)
        if (mon && DMWr && nw < 8) begin
            wcyc[nw] = cyc;
            wdat[nw] = WriteData;
            wadr[nw] = DataAddr;
            nw++;
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one request and follows it to done; lat=-1 if done never arrives
    task automatic run_req(input logic [3:0] op, input logic [11:0] a, input logic [31:0] wd,
                           output int lat, output int nrd, output int nwr, output logic e,
                           output logic [9:0] wa);
        lat = -1; nrd = 0; nwr = 0; e = 0; wa = 0;
        @(negedge clk);
        req_valid = 1; req_op = op; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            if (DMRd) nrd++;
            if (DMWr) begin nwr++; wa = DataAddr; end
            if (done) begin lat = k; e = err; break; end
            @(negedge clk);
        end
    endtask

    int lat, nrd, nwr, w, ndone;
    logic e;
    logic [9:0] wa;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 0;
        @(negedge clk);
        chk("rst_ready", {31'b0, req_ready}, 1);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rdwr", {30'b0, DMRd, DMWr}, 0);
        chk("rst_addr_wd", {DataAddr, WriteData[21:0]} | {10'b0, WriteData[31:22] != 0, 21'b0}, 0);
        rst = 0;

        run_req(4'b1011, 12'h010, 32'hDEADBEEF, lat, nrd, nwr, e, wa);
        chk("sw_lat", lat, 2);
        chk("sw_err", {31'b0, e}, 0);
        chk("sw_pulses", {nrd[15:0], nwr[15:0]}, 32'h0000_0001);
        chk("sw_addr", {22'b0, wa}, 32'h4);
        chk("sw_mem", mem[4], 32'hDEADBEEF);
        run_req(4'b0011, 12'h010, 0, lat, nrd, nwr, e, wa);
        chk("lw_lat", lat, 2);
        chk("lw_pulses", {nrd[15:0], nwr[15:0]}, 32'h0001_0000);
        chk("lw_data", rdata, 32'hDEADBEEF);

        mem[8] = 32'h80FF7F01;
        run_req(4'b0000, 12'h020, 0, lat, nrd, nwr, e, wa);
        chk("lb0", rdata, 32'h00000001);
        run_req(4'b0000, 12'h023, 0, lat, nrd, nwr, e, wa);
        chk("lb3", rdata, 32'hFFFFFF80);
        run_req(4'b0100, 12'h023, 0, lat, nrd, nwr, e, wa);
        chk("lbu3", rdata, 32'h00000080);
        run_req(4'b0001, 12'h022, 0, lat, nrd, nwr, e, wa);
        chk("lh2", rdata, 32'hFFFF80FF);
        run_req(4'b0101, 12'h022, 0, lat, nrd, nwr, e, wa);
        chk("lhu2", rdata, 32'h000080FF);
        chk("lhu_err", {31'b0, e}, 0);

        mem[12] = 32'h11223344;
        run_req(4'b1000, 12'h031, 32'h000000AB, lat, nrd, nwr, e, wa);
        chk("sb_lat", lat, 3);
        chk("sb_pulses", {nrd[15:0], nwr[15:0]}, 32'h0001_0001);
        chk("sb_mem", mem[12], 32'h1122AB44);
        run_req(4'b1001, 12'h032, 32'h0000CDEF, lat, nrd, nwr, e, wa);
        chk("sh_lat", lat, 3);
        chk("sh_pulses", {nrd[15:0], nwr[15:0]}, 32'h0001_0001);
        chk("sh_mem", mem[12], 32'hCDEFAB44);

        run_req(4'b0011, 12'h041, 0, lat, nrd, nwr, e, wa);
        chk("lw_mis_lat", lat, 1);
        chk("lw_mis_err", {31'b0, e}, 1);
        chk("lw_mis_pulses", {nrd[15:0], nwr[15:0]}, 0);
        chk("lw_mis_rdata", rdata, 32'h000080FF);
        run_req(4'b1001, 12'h043, 32'h1234, lat, nrd, nwr, e, wa);
        chk("sh_mis_lat", lat, 1);
        chk("sh_mis_err", {31'b0, e}, 1);
        chk("sh_mis_pulses", {nrd[15:0], nwr[15:0]}, 0);
        run_req(4'b0010, 12'h040, 0, lat, nrd, nwr, e, wa);
        chk("ill_lat", lat, 1);
        chk("ill_err", {31'b0, e}, 1);
        chk("ill_pulses", {nrd[15:0], nwr[15:0]}, 0);
        chk("ill_rdata", rdata, 32'h000080FF);

        // Abort an SB in its WRITE cycle
        mem[16] = 32'h55667788;
        @(negedge clk);
        req_valid = 1; req_op = 4'b1000; req_addr = 12'h040; req_wdata = 32'h99;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("abort_read", {31'b0, DMRd}, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("abort_dmwr", {31'b0, DMWr}, 0);
        chk("abort_ready_in_rst", {31'b0, req_ready}, 1);
        @(negedge clk);
        rst = 0;
        #1;
        chk("abort_ready_after", {31'b0, req_ready}, 1);
        chk("abort_rdata", rdata, 0);
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_mem", mem[16], 32'h55667788);

        // Three SW with req_valid held high throughout
        nw = 0; mon = 1;
        req_valid = 1; req_op = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            w = 0;
            while (!req_ready && w < 20) begin @(negedge clk); w++; end
            req_addr = 12'h050 + 12'(4 * i);
            req_wdata = 32'hA0A0_0000 + i;
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 0;
        repeat (6) @(negedge clk);
        mon = 0;
        chk("b2b_count", nw, 3);
        chk("b2b_gap01", wcyc[1] - wcyc[0], 3);
        chk("b2b_gap12", wcyc[2] - wcyc[1], 3);
        chk("b2b_d0", wdat[0], 32'hA0A00000);
        chk("b2b_d1", wdat[1], 32'hA0A00001);
        chk("b2b_d2", wdat[2], 32'hA0A00002);
        chk("b2b_a2", {22'b0, wadr[2]}, 32'h16);
        chk("b2b_mem1", mem[21], 32'hA0A00001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
